// File: rtl/usart_tx_arbiter.sv
// Round-robin arbiter feeding one 8N1 serial transmitter.
// Owns the bit-rate divider and the frame sequencer.
module usart_tx_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int CLK_DIV = 138
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [8*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [(NUM_REQ > 1 ? $clog2(NUM_REQ) : 1)-1:0] grant_id,
  output logic                  busy,
  output logic                  tx_pin
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(CLK_DIV);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   win;
  logic [IW-1:0]   idx;
  logic            found;
  logic [7:0]      shreg;
  logic [CW-1:0]   div;
  logic [2:0]      bitcnt;
  logic            tick;

  assign tick = (div == CW'(CLK_DIV - 1));

  // Pick the first valid requester after the last winner, with wrap.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IW'((int'(ptr) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Ready only while idle and out of reset, one-hot on the winner.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && !reset && found)
      req_ready = NUM_REQ'(1) << win;
  end

  // Frame sequencer: start bit, 8 data bits LSB first, stop bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= IW'(NUM_REQ - 1);
      grant_id <= '0;
      shreg    <= '0;
      div      <= '0;
      bitcnt   <= '0;
      busy     <= 1'b0;
      tx_pin   <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          tx_pin <= 1'b1;
          if (found) begin
            shreg    <= req_data[8*win +: 8];
            grant_id <= win;
            ptr      <= win;
            div      <= '0;
            bitcnt   <= '0;
            busy     <= 1'b1;
            tx_pin   <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (tick) begin
            div    <= '0;
            tx_pin <= shreg[0];
            shreg  <= shreg >> 1;
            state  <= DATA;
          end else begin
            div <= div + 1'b1;
          end
        end
        DATA: begin
          if (tick) begin
            div <= '0;
            if (bitcnt == 3'd7) begin
              tx_pin <= 1'b1;
              state  <= STOP;
            end else begin
              bitcnt <= bitcnt + 1'b1;
              tx_pin <= shreg[0];
              shreg  <= shreg >> 1;
            end
          end else begin
            div <= div + 1'b1;
          end
        end
        STOP: begin
          if (tick) begin
            div   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            div <= div + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usart_tx_arbiter.sv
// Directed bench for usart_tx_arbiter with NUM_REQ=2, CLK_DIV=4.
// Frames are driven from a vector table; reset corners are hand-written.
module tb_usart_tx_arbiter;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_ready;
  logic [0:0]  grant_id;
  logic        busy;
  logic        tx_pin;

  int checks = 0;
  int errors = 0;

  usart_tx_arbiter #(.NUM_REQ(2), .CLK_DIV(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .grant_id  (grant_id),
    .busy      (busy),
    .tx_pin    (tx_pin)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] valid;
    logic [7:0] d0;
    logic [7:0] d1;
    int         gid;
    logic [7:0] byt;
    bit         hold;
    bit         scr;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one table entry: wait for ready, then check the whole frame.
  task automatic send(input vec_t v);
    int w;
    logic e;
    req_valid = v.valid;
    req_data  = {v.d1, v.d0};
    w = 0;
    @(negedge clk);
    while (req_ready == 2'b00 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("ready_wait", w, 0);
    if (w >= 50) return;
    chk("idle_busy", int'(busy), 0);
    chk("idle_tx", int'(tx_pin), 1);
    chk("ready_onehot", int'(req_ready), 1 << v.gid);
    @(posedge clk);
    #1;
    if (!v.hold) req_valid = 2'b00;
    if (v.scr) req_data = ~req_data;
    for (int c = 0; c < 10 * D; c++) begin
      @(negedge clk);
      if (c < D) e = 1'b0;
      else if (c < 9 * D) e = v.byt[(c - D) / D];
      else e = 1'b1;
      if (c == 0) chk("grant_id", int'(grant_id), v.gid);
      chk("frame_tx", int'(tx_pin), int'(e));
      chk("frame_busy", int'(busy), 1);
      chk("frame_ready", int'(req_ready), 0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0] = '{2'b01, 8'hA5, 8'h00, 0, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{2'b11, 8'h3C, 8'hC3, 1, 8'hC3, 1'b1, 1'b0};
    tbl[2] = '{2'b11, 8'h3C, 8'hC3, 0, 8'h3C, 1'b1, 1'b0};
    tbl[3] = '{2'b11, 8'h3C, 8'hC3, 1, 8'hC3, 1'b1, 1'b0};
    tbl[4] = '{2'b11, 8'h3C, 8'hC3, 0, 8'h3C, 1'b0, 1'b0};
    tbl[5] = '{2'b01, 8'h5A, 8'h00, 0, 8'h5A, 1'b0, 1'b1};
    tbl[6] = '{2'b10, 8'h00, 8'h11, 1, 8'h11, 1'b0, 1'b0};
    tbl[7] = '{2'b10, 8'h00, 8'h22, 1, 8'h22, 1'b0, 1'b0};
    tbl[8] = '{2'b10, 8'h00, 8'h33, 1, 8'h33, 1'b0, 1'b0};

    reset     = 1'b1;
    req_valid = 2'b00;
    req_data  = 16'h0000;
    @(posedge clk);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("rst_tx", int'(tx_pin), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_ready", int'(req_ready), 0);
    end
    chk("rst_gid", int'(grant_id), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 9; i++) send(tbl[i]);

    // Reset during data bit 3 of a requester-1 frame.
    req_valid = 2'b10;
    req_data  = {8'hF7, 8'h00};
    @(negedge clk);
    chk("r1_ready", int'(req_ready), 2);
    @(posedge clk);
    #1;
    for (int c = 0; c <= 4 * D; c++) @(negedge clk);
    chk("bit3_tx", int'(tx_pin), 0);
    chk("bit3_busy", int'(busy), 1);
    chk("bit3_gid", int'(grant_id), 1);
    reset     = 1'b1;
    req_valid = 2'b11;
    req_data  = {8'h99, 8'h44};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("mid_rst_tx", int'(tx_pin), 1);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_ready", int'(req_ready), 0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    send('{2'b11, 8'h44, 8'h99, 0, 8'h44, 1'b0, 1'b0});

    // Idle with nothing valid: line stays high, no ready.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_hold_tx", int'(tx_pin), 1);
      chk("idle_hold_ready", int'(req_ready), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
